seg7_scan_mux: RTL and testbench
================================

Name: seg7_scan_mux

Overview:
- Parametrised N-digit multiplexed 7-segment driver with full hex decode (0-F), per-digit decimal point, and optional leading-zero blanking.
- Double-buffered so a value update never tears mid-frame.
- Anti-ghosting blank interval at each digit switch.
- Sits between counter/BCD logic and board segment/anode pins; clocked from the 100 MHz system clock.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_CYCLES, 100000, clocks per digit slot (1 ms at 100 MHz); must be > BLANK_CYCLES.
- BLANK_CYCLES, 1000, clocks at the start of each slot with all anodes off.
- SEG_ACTIVE_LOW, 1, 1 = segments and dp driven low to light.
- DIGIT_ACTIVE_LOW, 1, 1 = anode enables driven low to select.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  nibble k = digit k value; digit 0 = rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- load  in  1  single-cycle strobe; captures digits_in/dp_in into pending buffer.
- blank_lz  in  1  1 = blank leading zeros (digit 0 never blanked).
- seg  out  [0:6]  segments a..g, seg[0]=a, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point, same polarity as seg.
- digit  out  NUM_DIGITS  anode enables, one-hot when active, polarity per DIGIT_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- **Reset (async, immediate):**
  - slot_timer=0, sel=0; pending and active buffers all zero.
  - seg/dp all unlit, digit all inactive, frame_done=0.
- **Slot timer:**
  - Counts 0..REFRESH_CYCLES-1, then returns to 0 and advances sel.
  - sel wraps NUM_DIGITS-1 -> 0.
  - frame_done pulses in the cycle the timer wraps while sel==NUM_DIGITS-1.
- **Buffering:**
  - load=1 copies inputs to pending in that cycle and sets a pending_valid flag.
  - When sel wraps to 0 and pending_valid=1, active <= pending and the flag clears.
  - A load in the same cycle as the wrap goes to pending only, and is shown next frame.
  - Repeated loads within a frame: the last one wins.
- **Decode:**
  - Nibble 0-F maps to standard glyphs: 0,1,2,3,4,5,6,7,8,9,A,b,C,d,E,F.
  - No default-less cases; every input value has a defined output.
- **Leading-zero blanking:** with blank_lz=1, digit k (k>0) is blanked when it and all higher digits of active are 0.
  - Blanked means all segments off.
  - dp still follows dp_in for that digit.
- **Guard interval:** while slot_timer < BLANK_CYCLES, digit is all inactive; otherwise digit is one-hot at sel.
- **Output timing:**
  - seg, dp and digit are registered.
  - Outputs reflect sel/slot_timer with exactly 1 clock latency.
  - seg/dp change only in a cycle where digit is inactive.
- **Polarity:** applied at the output register; internal logic is active-high.

Optional Feature:
- Macro: SEG7_BRIGHTNESS_EN.
- Defined:
  - Adds input port brightness [3:0] and a 4-bit free-running pwm_cnt (reset 0, +1 every clock).
  - Outside the guard interval, the selected digit is active only when pwm_cnt < brightness, or when brightness==15 (always active).
  - brightness==0 keeps all digits dark; frame timing and frame_done are unaffected.
- Not defined: no port and no counter; digits are fully on outside the guard interval.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry glyph constant table (active-high, a..g);
  - SEG_OFF/SEG_ALL constants;
  - a seg7_glyph_t 7-bit typedef.
- Sub-module seg7_hex_decode: purely combinational nibble -> glyph, one instance in the output path.
- Timer, buffering, blanking and output registers stay in seg7_scan_mux.

Test Plan (NUM_DIGITS=4, REFRESH_CYCLES=8, BLANK_CYCLES=2, active-low):
- Reset mid-slot (sel=2, timer=5) -> next sample shows seg=7'h7F, digit=4'hF, frame_done=0; scan restarts at sel=0.
- Load 16'h12AF, blank_lz=0 -> from next frame, digit0 shows F, digit1 A, digit2 2, digit3 1.
  - Each digit is low for 6 of 8 cycles per slot.
  - frame_done period = 32 clocks.
- Load 16'h0007 with blank_lz=1, dp_in=4'b0100 -> digits 3 and 1 fully unlit, digit0 shows 7, digit2 shows only dp=0.
- Load 16'h1111, then load 16'h2222 mid-frame -> the current frame keeps 1111; the next frame shows 2222, never 1111 mixed with 2222.
- Load asserted in the exact sel-wrap cycle -> the old value is shown for one more full frame, then the new value.
- SEG7_BRIGHTNESS_EN, brightness=4 -> outside guard, the selected anode is low exactly when pwm_cnt<4.
  - brightness=0: digit stays 4'hF throughout.
  - brightness=15: matches the behaviour with the macro not defined.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph table and segment types for the 7-segment scan driver.
// Glyph bit order is a..g from the left (glyph[0] = a), active-high.
package seg7_pkg;

    typedef logic [0:6] seg7_glyph_t;

    localparam seg7_glyph_t SEG_OFF = 7'b0000000;
    localparam seg7_glyph_t SEG_ALL = 7'b1111111;

    localparam seg7_glyph_t GLYPH_TABLE [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high a..g glyph; every nibble value
// has a table entry, so there is no undefined output.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]  nibble,
    output seg7_glyph_t glyph
);

    assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit multiplexed 7-segment driver: double-buffered value, hex decode,
// leading-zero blanking, anti-ghost guard. Optional macro SEG7_BRIGHTNESS_EN adds PWM dimming.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_CYCLES   = 100000,
    parameter int BLANK_CYCLES     = 1000,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]              brightness,
`endif
    output logic [0:6]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic                    frame_done
);

    localparam int TIMER_W = $clog2(REFRESH_CYCLES);
    localparam int SEL_W   = $clog2(NUM_DIGITS);

    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(REFRESH_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    BLANK_LIM  = TIMER_W'(BLANK_CYCLES);
    localparam logic [SEL_W-1:0]      SEL_LAST   = SEL_W'(NUM_DIGITS - 1);
    localparam seg7_glyph_t           SEG_POL    = SEG_ACTIVE_LOW ? SEG_ALL : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] DIG_POL    = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

    logic [TIMER_W-1:0]      slot_timer;
    logic [SEL_W-1:0]        sel;
    logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic                    pend_valid;

    logic                    timer_wrap, frame_wrap, in_guard, pwm_on;
    logic [3:0]              cur_nibble;
    logic                    cur_dp, cur_hi_zero, zero_run;
    logic [NUM_DIGITS-1:0]   digit_hi;
    seg7_glyph_t             cur_glyph, seg_hi;

    assign timer_wrap = (slot_timer == TIMER_LAST);
    assign frame_wrap = timer_wrap && (sel == SEL_LAST);
    assign in_guard   = (slot_timer < BLANK_LIM);
    assign frame_done = frame_wrap;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            slot_timer <= '0;
            sel        <= '0;
        end else if (timer_wrap) begin
            slot_timer <= '0;
            sel        <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
        end else begin
            slot_timer <= slot_timer + TIMER_W'(1);
        end
    end

    // The load after the frame swap wins, so a strobe in the wrap cycle waits a frame.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            act_digits  <= '0;
            act_dp      <= '0;
        end else begin
            if (frame_wrap && pend_valid) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
                pend_valid <= 1'b0;
            end
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_valid  <= 1'b1;
            end
        end
    end

`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) pwm_cnt <= 4'h0;
        else       pwm_cnt <= pwm_cnt + 4'h1;
    end

    assign pwm_on = (brightness == 4'hF) || (pwm_cnt < brightness);
`else
    assign pwm_on = 1'b1;
`endif

    // Scan from the top digit down so zero_run means "this and all higher digits are zero".
    always_comb begin
        cur_nibble  = 4'h0;
        cur_dp      = 1'b0;
        cur_hi_zero = 1'b0;
        zero_run    = 1'b1;
        digit_hi    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (act_digits[4*k +: 4] == 4'h0);
            if (SEL_W'(k) == sel) begin
                cur_nibble  = act_digits[4*k +: 4];
                cur_dp      = act_dp[k];
                cur_hi_zero = zero_run;
                digit_hi[k] = !in_guard && pwm_on;
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .glyph  (cur_glyph)
    );

    assign seg_hi = (blank_lz && (sel != '0) && cur_hi_zero) ? SEG_OFF : cur_glyph;

    // Segment data is only refreshed during the guard, so it never changes under a lit anode.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            seg   <= SEG_OFF ^ SEG_POL;
            dp    <= SEG_ACTIVE_LOW;
            digit <= DIG_POL;
        end else begin
            if (in_guard) begin
                seg <= seg_hi ^ SEG_POL;
                dp  <= cur_dp ^ SEG_ACTIVE_LOW;
            end
            digit <= digit_hi ^ DIG_POL;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: 4 digits, 8-clock slots, 2-clock guard, active-low.
module tb_seg7_scan_mux;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int B  = 2;
    localparam int NR = N * R;

    logic        clk_100MHz;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic [0:6]  seg;
    logic        dp;
    logic [3:0]  digit;
    logic        frame_done;

    seg7_scan_mux #(
        .NUM_DIGITS       (N),
        .REFRESH_CYCLES   (R),
        .BLANK_CYCLES     (B),
        .SEG_ACTIVE_LOW   (1'b1),
        .DIGIT_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
`ifdef SEG7_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .seg        (seg),
        .dp         (dp),
        .digit      (digit),
        .frame_done (frame_done)
    );

    // clock / reset
    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    // reference model state: k = clocks since reset release
    int          k;
    logic [15:0] pend_d, act_d;
    logic [3:0]  pend_dp, act_dp;
    logic        pend_v;

    // scoreboard: {seg[0:6], dp, digit[3:0], frame_done}
    logic [12:0] exp_q[$];
    int          tag_q[$];
    int          vectors;
    int          miscompares;

    string seg_names [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                              "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [0:6] glyph_ref(input logic [3:0] v);
        logic [0:6] g;
        string      s;
        g = '0;
        s = seg_names[v];
        for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b1;
        return g;
    endfunction

    // Drive one clock of inputs at the current negedge, predict the outputs after the next posedge.
    task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] dpv);
        int          t, s;
        logic [3:0]  nib;
        logic [0:6]  g;
        logic [3:0]  dig;
        logic        on, fd;
        load      = ld;
        digits_in = d;
        dp_in     = dpv;
        t   = k % R;
        s   = (k / R) % N;
        nib = act_d[4*s +: 4];
        g   = (blank_lz && s > 0 && (act_d >> (4*s)) == 16'h0) ? 7'b0 : glyph_ref(nib);
        on  = (t >= B);
`ifdef SEG7_BRIGHTNESS_EN
        on  = on && (brightness == 4'hF || (k % 16) < int'(brightness));
`endif
        dig = on ? 4'(1 << s) : 4'h0;
        fd  = ((k + 2) % NR == 0);
        exp_q.push_back({~g, ~act_dp[s], ~dig, fd});
        tag_q.push_back(k);
        if ((k + 1) % NR == 0 && pend_v) begin
            act_d  = pend_d;
            act_dp = pend_dp;
            pend_v = 1'b0;
        end
        if (ld) begin
            pend_d  = d;
            pend_dp = dpv;
            pend_v  = 1'b1;
        end
        k++;
        @(negedge clk_100MHz);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom_range(0, 16'hFFFF), 4'($urandom_range(0, 15)));
    endtask

    // Called at a negedge; asserts reset, checks the immediate async response, releases at a negedge.
    task automatic do_reset(input logic bl, input logic rnd_br);
        logic [12:0] got;
        reset      = 1'b1;
        load       = 1'b0;
        blank_lz   = bl;
        brightness = rnd_br ? 4'($urandom_range(0, 15)) : 4'hF;
        #1;
        got = {seg, dp, digit, frame_done};
        vectors++;
        if (got !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", got, {7'h7F, 1'b1, 4'hF, 1'b0});
        end
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        k = 0;
        pend_d = '0; act_d = '0; pend_dp = '0; act_dp = '0; pend_v = 1'b0;
        reset = 1'b0;
    endtask

    // monitor
    initial begin
        logic [12:0] e, got;
        int          tg;
        forever begin
            @(posedge clk_100MHz);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                tg  = tag_q.pop_front();
                got = {seg, dp, digit, frame_done};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL scan k=%0d br=%0d seg/dp/digit/fd got=%b_%b_%b_%b exp=%b_%b_%b_%b",
                             tg, brightness, got[12:6], got[5], got[4:1], got[0], e[12:6], e[5], e[4:1], e[0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        vectors = 0; miscompares = 0; k = 0;
        reset = 1'b1; load = 1'b0; blank_lz = 1'b0; digits_in = '0; dp_in = '0; brightness = 4'hF;
        pend_d = '0; act_d = '0; pend_dp = '0; act_dp = '0; pend_v = 1'b0;
        @(negedge clk_100MHz);

        // reset, then a second reset mid-slot at sel=2 / timer=5
        do_reset(1'b0, 1'b0);
        idle(21);
        do_reset(1'b0, 1'b0);
        idle(40);

        // plain hex with decimal points off
        do_reset(1'b0, 1'b0);
        cycle(1'b1, 16'h12AF, 4'b0000);
        idle(3 * NR);

        // leading-zero blanking with dp on a blanked digit
        do_reset(1'b1, 1'b0);
        cycle(1'b1, 16'h0007, 4'b0100);
        idle(3 * NR);

        // mid-frame reload must not tear
        do_reset(1'b0, 1'b0);
        cycle(1'b1, 16'h1111, 4'b0001);
        idle(NR + 12);
        cycle(1'b1, 16'h2222, 4'b0010);
        idle(2 * NR);

        // load in the exact wrap cycle is deferred one frame
        do_reset(1'b0, 1'b0);
        cycle(1'b1, 16'h3333, 4'b1000);
        idle(NR - 2);
        cycle(1'b1, 16'h4444, 4'b0100);
        idle(3 * NR);

        // randomized loads, blanking and (if built in) brightness
        for (int r = 0; r < 8; r++) begin
            do_reset(1'($urandom_range(0, 1)), 1'b1);
            for (int c = 0; c < 6 * NR; c++) begin
                if ($urandom_range(0, 19) == 0)
                    cycle(1'b1, 16'($urandom_range(0, 16'hFFFF)) & (($urandom_range(0, 1) == 1) ? 16'h00FF : 16'hFFFF),
                          4'($urandom_range(0, 15)));
                else
                    cycle(1'b0, 16'($urandom_range(0, 16'hFFFF)), 4'($urandom_range(0, 15)));
            end
        end

        @(posedge clk_100MHz);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
